// File: rtl/lock_pkg.sv
// Shared types and helpers for the six-digit lock controller.
// Key codes, state encoding and entry-buffer digit placement.
package lock_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_EVAL,
    S_UNLOCKED,
    S_NEW_PW,
    S_ERROR,
    S_LOCKOUT
  } state_e;

  localparam logic [3:0] KEY_ENT = 4'hA;
  localparam logic [3:0] KEY_CLR = 4'hB;
  localparam logic [3:0] KEY_CHG = 4'hC;

  localparam int PW_DIGITS = 6;

  function automatic logic is_digit(input logic [3:0] c);
    return c <= 4'd9;
  endfunction

  // First digit lands in bits 23:20, later digits fill downward.
  function automatic logic [23:0] put_digit(
    input logic [23:0] b,
    input logic [2:0]  n,
    input logic [3:0]  c
  );
    logic [23:0] r;
    r = b;
    for (int i = 0; i < PW_DIGITS; i++) begin
      if (n == 3'(i)) r[23-4*i -: 4] = c;
    end
    return r;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the timed lock states.
// done_o is high in the final enabled cycle of a loaded interval.
module lock_timer
  import lock_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  // Load on state entry, count down while enabled, hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/lock_ctrl.sv
// Sequencing controller for the six-digit electronic lock.
// Entry buffer, stored password, judge handshake, timed states.
module lock_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned UNLOCK_CYCLES  = 50_000_000,
  parameter int unsigned ERR_CYCLES     = 25_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 250_000_000,
  parameter logic [23:0] DEFAULT_PW     = 24'h123456
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        judge_s,
  output logic [23:0] a_digits,
  output logic [23:0] b_digits,
  input  logic        judge_c,
  output logic        unlocked,
  output logic        err,
  output logic        alarm,
  output logic [2:0]  digit_cnt,
  output logic [2:0]  state_o
);

  localparam int unsigned MAX_UE =
    (UNLOCK_CYCLES > ERR_CYCLES) ? UNLOCK_CYCLES : ERR_CYCLES;
  localparam int unsigned MAXC =
    (MAX_UE > LOCKOUT_CYCLES) ? MAX_UE : LOCKOUT_CYCLES;
  localparam int unsigned TW = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [TW-1:0] UNL_LD = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] ERR_LD = TW'(ERR_CYCLES - 1);
  localparam logic [TW-1:0] LCK_LD = TW'(LOCKOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [23:0]   buf_q, buf_d;
  logic [23:0]   pw_q, pw_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [2:0]    fail_q, fail_d;
  logic          judge_q, unl_q, err_q, alarm_q;

  logic          k_dig, k_ent, k_clr, k_chg;
  logic          full, fail;
  logic          tmr_ld, tmr_en, tmr_done;
  logic [TW-1:0] tmr_val;

  assign k_dig = key_valid && is_digit(key_code);
  assign k_ent = key_valid && key_code == KEY_ENT;
  assign k_clr = key_valid && key_code == KEY_CLR;
  assign k_chg = key_valid && key_code == KEY_CHG;
  assign full  = cnt_q == 3'(PW_DIGITS);

  assign tmr_en = state_q == S_UNLOCKED ||
                  state_q == S_ERROR ||
                  state_q == S_LOCKOUT;

  lock_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (tmr_ld),
    .val_i  (tmr_val),
    .en_i   (tmr_en),
    .done_o (tmr_done)
  );

  // Next-state, buffer, password and failure bookkeeping.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    pw_d    = pw_q;
    fail_d  = fail_q;
    fail    = 1'b0;
    tmr_ld  = 1'b0;
    tmr_val = '0;

    unique case (state_q)
      S_IDLE, S_ENTRY: begin
        unique case (1'b1)
          k_dig: begin
            if (!full) begin
              buf_d   = put_digit(buf_q, cnt_q, key_code);
              cnt_d   = cnt_q + 3'd1;
              state_d = S_ENTRY;
            end
          end
          k_clr: begin
            buf_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end
          k_ent: begin
            if (full) state_d = S_CHECK;
            else      fail    = 1'b1;
          end
          default: ;
        endcase
      end
      S_CHECK: state_d = S_EVAL;
      S_EVAL: begin
        if (judge_c) begin
          fail_d  = '0;
          buf_d   = '0;
          cnt_d   = '0;
          state_d = S_UNLOCKED;
        end else begin
          fail = 1'b1;
        end
      end
      S_UNLOCKED: begin
        if (tmr_done || k_ent) state_d = S_IDLE;
        else if (k_chg)        state_d = S_NEW_PW;
      end
      S_NEW_PW: begin
        unique case (1'b1)
          k_dig: begin
            if (!full) begin
              buf_d = put_digit(buf_q, cnt_q, key_code);
              cnt_d = cnt_q + 3'd1;
            end
          end
          k_clr: begin
            buf_d = '0;
            cnt_d = '0;
          end
          k_ent: begin
            if (full) begin
              pw_d    = buf_q;
              buf_d   = '0;
              cnt_d   = '0;
              state_d = S_IDLE;
            end
          end
          k_chg: begin
            buf_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end
          default: ;
        endcase
      end
      S_ERROR: begin
        if (tmr_done) state_d = S_IDLE;
      end
      S_LOCKOUT: begin
        if (tmr_done) begin
          fail_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      fail_d  = fail_q + 3'd1;
      buf_d   = '0;
      cnt_d   = '0;
      state_d = (fail_d == 3'(MAX_FAIL)) ? S_LOCKOUT : S_ERROR;
    end

    if (state_d != state_q) begin
      unique case (state_d)
        S_UNLOCKED: begin tmr_ld = 1'b1; tmr_val = UNL_LD; end
        S_ERROR:    begin tmr_ld = 1'b1; tmr_val = ERR_LD; end
        S_LOCKOUT:  begin tmr_ld = 1'b1; tmr_val = LCK_LD; end
        default: ;
      endcase
    end
  end

  // State, datapath and registered output decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      pw_q    <= DEFAULT_PW;
      fail_q  <= '0;
      judge_q <= 1'b0;
      unl_q   <= 1'b0;
      err_q   <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      pw_q    <= pw_d;
      fail_q  <= fail_d;
      judge_q <= state_d == S_CHECK;
      unl_q   <= state_d == S_UNLOCKED || state_d == S_NEW_PW;
      err_q   <= state_d == S_ERROR;
      alarm_q <= state_d == S_LOCKOUT;
    end
  end

  assign judge_s   = judge_q;
  assign a_digits  = buf_q;
  assign b_digits  = pw_q;
  assign unlocked  = unl_q;
  assign err       = err_q;
  assign alarm     = alarm_q;
  assign digit_cnt = cnt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// Self-checking bench for lock_ctrl with scaled-down timings.
// A registered judge model sits beside the controller.
module tb_lock_ctrl;
  import lock_pkg::*;

  localparam int MF = 3;
  localparam int UC = 10;
  localparam int EC = 5;
  localparam int LC = 12;
  localparam logic [23:0] DPW = 24'h123456;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        judge_s, judge_c;
  logic [23:0] a_digits, b_digits;
  logic        unlocked, err, alarm;
  logic [2:0]  digit_cnt, state_o;

  int vec = 0;
  int errs = 0;

  int pw_m[6];
  int ent_q[$];
  int fail_m;

  lock_ctrl #(
    .MAX_FAIL(MF), .UNLOCK_CYCLES(UC), .ERR_CYCLES(EC),
    .LOCKOUT_CYCLES(LC), .DEFAULT_PW(DPW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_code(key_code),
    .judge_s(judge_s), .a_digits(a_digits), .b_digits(b_digits),
    .judge_c(judge_c), .unlocked(unlocked), .err(err),
    .alarm(alarm), .digit_cnt(digit_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) judge_c <= 1'b0;
    else if (judge_s) judge_c <= (a_digits == b_digits);
  end

  function automatic logic [23:0] ent_val();
    logic [23:0] r = '0;
    foreach (ent_q[i]) r = r | (24'(ent_q[i]) << (20 - 4*i));
    return r;
  endfunction

  function automatic logic [23:0] pw_val();
    logic [23:0] r = '0;
    for (int i = 0; i < 6; i++) r = r | (24'(pw_m[i]) << (20 - 4*i));
    return r;
  endfunction

  function automatic logic [23:0] wrong_code();
    logic [23:0] r;
    do begin
      for (int i = 0; i < 6; i++) r[23-4*i -: 4] = 4'($urandom_range(0, 9));
    end while (r == pw_val());
    return r;
  endfunction

  task automatic model_reset();
    logic [23:0] d = DPW;
    for (int i = 0; i < 6; i++) pw_m[i] = int'(d[23-4*i -: 4]);
    ent_q.delete();
    fail_m = 0;
  endtask

  task automatic press(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic key(input logic [3:0] c);
    press(c);
    if (c <= 4'd9) begin
      if (ent_q.size() < 6) ent_q.push_back(int'(c));
    end else if (c == KEY_CLR) begin
      ent_q.delete();
    end
    vec++;
    if (digit_cnt !== 3'(ent_q.size())) begin
      errs++;
      $display("FAIL key_cnt code=%h got %0d want %0d", c, digit_cnt, ent_q.size());
    end
    vec++;
    if (a_digits !== ent_val()) begin
      errs++;
      $display("FAIL key_buf code=%h got %h want %h", c, a_digits, ent_val());
    end
  endtask

  task automatic enter6(input logic [23:0] v);
    for (int i = 0; i < 6; i++) key(v[23-4*i -: 4]);
  endtask

  // Called right after ENT: predicts the whole attempt and measures it.
  task automatic observe(input string tag);
    bit full, match, done;
    int nf, ej, eu, ee, ea, k;
    int nj, nu, ne, na, jp, up;
    logic [23:0] ev, as;
    full  = ent_q.size() == 6;
    ev    = ent_val();
    match = full && ev == pw_val();
    nf    = match ? 0 : fail_m + 1;
    ej    = full ? 1 : 0;
    eu    = match ? UC : 0;
    ee    = (!match && nf < MF) ? EC : 0;
    ea    = (!match && nf >= MF) ? LC : 0;
    fail_m = (ea != 0) ? 0 : nf;
    ent_q.delete();
    done = 0; nj = 0; nu = 0; ne = 0; na = 0; jp = -1; up = -1; as = '0;
    for (int c = 0; c < 400; c++) begin
      if (state_o == S_IDLE) begin done = 1; break; end
      if (judge_s) begin nj++; if (jp < 0) begin jp = c; as = a_digits; end end
      if (unlocked) begin nu++; if (up < 0) up = c; end
      if (err) ne++;
      if (alarm) na++;
      if ((err || alarm || unlocked) && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 15);
        if (unlocked && (k == 10 || k == 12)) k = 13;
        key_valid = 1'b1;
        key_code  = 4'(k);
      end else begin
        key_valid = 1'b0;
      end
      @(negedge clk);
    end
    key_valid = 1'b0;
    vec++;
    if (!done) begin errs++; $display("FAIL %s timeout got busy want idle", tag); end
    vec++;
    if (nj != ej) begin errs++; $display("FAIL %s judge_cycles got %0d want %0d", tag, nj, ej); end
    vec++;
    if (nu != eu) begin errs++; $display("FAIL %s unlock_cycles got %0d want %0d", tag, nu, eu); end
    vec++;
    if (ne != ee) begin errs++; $display("FAIL %s err_cycles got %0d want %0d", tag, ne, ee); end
    vec++;
    if (na != ea) begin errs++; $display("FAIL %s alarm_cycles got %0d want %0d", tag, na, ea); end
    if (ej != 0) begin
      vec++;
      if (as !== ev) begin errs++; $display("FAIL %s a_at_strobe got %h want %h", tag, as, ev); end
    end
    if (match) begin
      vec++;
      if (up - jp != 2) begin errs++; $display("FAIL %s unlock_latency got %0d want 2", tag, up - jp); end
    end
    vec++;
    if ({digit_cnt, a_digits, b_digits} !== {3'd0, 24'd0, pw_val()}) begin
      errs++;
      $display("FAIL %s idle_regs got %h/%h/%h want 0/0/%h", tag, digit_cnt, a_digits, b_digits, pw_val());
    end
  endtask

  task automatic open_lock();
    enter6(pw_val());
    press(KEY_ENT);
    ent_q.delete();
    fail_m = 0;
    for (int c = 0; c < 20 && !unlocked; c++) @(negedge clk);
    vec++;
    if (unlocked !== 1'b1) begin errs++; $display("FAIL open_lock unlocked got %b want 1", unlocked); end
  endtask

  task automatic check_reset_regs(input string tag);
    vec++;
    if ({judge_s, unlocked, err, alarm, digit_cnt, a_digits, b_digits, state_o} !==
        {4'b0, 3'd0, 24'd0, DPW, 3'(S_IDLE)}) begin
      errs++;
      $display("FAIL %s reset_regs got j%b u%b e%b a%b c%0d a%h b%h s%0d want all 0 b=%h",
               tag, judge_s, unlocked, err, alarm, digit_cnt, a_digits, b_digits, state_o, DPW);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_regs("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_regs("reset_released");
  endtask

  task automatic test_unlock();
    enter6(pw_val());
    press(KEY_ENT);
    observe("unlock");
  endtask

  task automatic test_short_entry();
    key(4'd1); key(4'd2); key(4'd3);
    press(KEY_ENT);
    observe("short");
    enter6(wrong_code());
    key(4'($urandom_range(0, 9)));
    key(KEY_CLR);
    key(4'd7); key(4'hD); key(4'hE); key(4'hF); key(KEY_CHG); key(4'd8);
    key(KEY_CLR);
    enter6(pw_val());
    press(KEY_ENT);
    observe("short_recover");
  endtask

  task automatic test_lockout();
    for (int i = 0; i < MF + 2; i++) begin
      enter6(wrong_code());
      press(KEY_ENT);
      observe("lockout");
    end
    enter6(pw_val());
    press(KEY_ENT);
    observe("lockout_recover");
  endtask

  task automatic test_change_pw();
    logic [23:0] np, old;
    np = 24'h987654;
    open_lock();
    press(KEY_CHG);
    vec++;
    if ({state_o, unlocked} !== {3'(S_NEW_PW), 1'b1}) begin
      errs++; $display("FAIL chg_enter got s%0d u%b want s%0d u1", state_o, unlocked, S_NEW_PW);
    end
    key(4'd1); key(4'd2); key(4'd3);
    press(KEY_ENT);
    vec++;
    if ({state_o, digit_cnt, b_digits} !== {3'(S_NEW_PW), 3'd3, pw_val()}) begin
      errs++; $display("FAIL chg_short_ent got s%0d c%0d b%h want s%0d c3 b%h",
                       state_o, digit_cnt, b_digits, S_NEW_PW, pw_val());
    end
    key(KEY_CLR);
    enter6(np);
    press(KEY_ENT);
    ent_q.delete();
    old = pw_val();
    for (int i = 0; i < 6; i++) pw_m[i] = int'(np[23-4*i -: 4]);
    vec++;
    if ({b_digits, state_o, unlocked, digit_cnt} !== {np, 3'(S_IDLE), 1'b0, 3'd0}) begin
      errs++; $display("FAIL chg_commit got b%h s%0d u%b c%0d want b%h s0 u0 c0",
                       b_digits, state_o, unlocked, digit_cnt, np);
    end
    enter6(old);
    press(KEY_ENT);
    observe("old_pw");
    enter6(np);
    press(KEY_ENT);
    observe("new_pw");
    open_lock();
    press(KEY_CHG);
    key(4'd5); key(4'd5);
    press(KEY_CHG);
    ent_q.delete();
    vec++;
    if ({b_digits, state_o, unlocked, digit_cnt} !== {pw_val(), 3'(S_IDLE), 1'b0, 3'd0}) begin
      errs++; $display("FAIL chg_abort got b%h s%0d u%b c%0d want b%h s0 u0 c0",
                       b_digits, state_o, unlocked, digit_cnt, pw_val());
    end
  endtask

  task automatic test_random();
    int n, good, j;
    for (int a = 0; a < 16; a++) begin
      n = $urandom_range(0, 8);
      good = $urandom_range(0, 1);
      for (int i = 0; i < n; i++) begin
        j = $urandom_range(0, 11);
        if (j == 0) key(4'($urandom_range(11, 15)));
        else if (good != 0 && ent_q.size() < 6) key(4'(pw_m[ent_q.size()]));
        else key(4'($urandom_range(0, 9)));
      end
      press(KEY_ENT);
      observe("random");
    end
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_reset_regs(tag);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    enter6(pw_val());
    press(KEY_ENT);
    @(negedge clk);
    vec++;
    if (state_o !== 3'(S_EVAL)) begin errs++; $display("FAIL mid_eval state got %0d want %0d", state_o, S_EVAL); end
    pulse_reset("rst_eval");
    open_lock();
    pulse_reset("rst_unlocked");
    for (int i = 0; i < MF - 1; i++) begin
      enter6(wrong_code());
      press(KEY_ENT);
      observe("pre_lock");
    end
    enter6(wrong_code());
    press(KEY_ENT);
    ent_q.delete();
    for (int c = 0; c < 10 && !alarm; c++) @(negedge clk);
    vec++;
    if (alarm !== 1'b1) begin errs++; $display("FAIL mid_lockout alarm got %b want 1", alarm); end
    repeat (3) @(negedge clk);
    pulse_reset("rst_lockout");
    test_unlock();
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_short_entry();
    test_lockout();
    test_change_pw();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/lock_ctrl.md
Name: lock_ctrl

Overview:
Sequencing controller for the six-digit electronic lock. It collects keypad digits into an entry buffer and holds the stored password. It drives the comparator (judge) strobe and samples its match result. It also manages the unlock window, failure counting with alarm lockout, and password change.

Parameters:
MAX_FAIL, 3, consecutive failed attempts that trigger lockout (1..7).
UNLOCK_CYCLES, 50_000_000, clock cycles the lock stays open.
ERR_CYCLES, 25_000_000, clock cycles the error indication is held.
LOCKOUT_CYCLES, 250_000_000, clock cycles of alarm lockout.
DEFAULT_PW, 24'h123456, password loaded at reset (6 BCD nibbles, MSB = first digit).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle pulse; key_code is valid (debounced upstream)
key_code  in  4  0-9 digit; 4'hA ENT; 4'hB CLR; 4'hC CHG
judge_s  out  1  compare strobe to judge
a_digits  out  24  entered digits {a1..a6} to judge
b_digits  out  24  stored password {b1..b6} to judge
judge_c  in  1  match result from judge
unlocked  out  1  lock open
err  out  1  wrong-code indication
alarm  out  1  lockout alarm
digit_cnt  out  3  digits currently in entry buffer (0..6)
state_o  out  3  current FSM state encoding (debug/display)

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; entry buffer=0; digit_cnt=0; stored pw=DEFAULT_PW; fail_cnt=0; timer=0.
  - judge_s=0, unlocked=0, err=0, alarm=0. All outputs are registered.
- Keys act only in the cycle key_valid=1. Codes 4'hD-4'hF are ignored in every state.
- States: IDLE, ENTRY, CHECK, EVAL, UNLOCKED, NEW_PW, ERROR, LOCKOUT.
- IDLE/ENTRY:
  - Digit with digit_cnt<6: shift into buffer at the next nibble position (first digit -> a1 = bits 23:20); digit_cnt+1; state ENTRY.
  - 7th and later digits are ignored.
  - CLR: buffer=0, cnt=0, state IDLE.
  - ENT with cnt==6 -> CHECK.
  - ENT with cnt<6 is a failure (same path as mismatch).
  - CHG is ignored.
- CHECK: judge_s=1 for exactly one cycle -> EVAL.
- EVAL:
  - judge_s=0; judge_c is sampled this cycle (one cycle after strobe).
  - Match: fail_cnt=0 -> UNLOCKED.
  - Mismatch: fail_cnt+1. If the new value == MAX_FAIL -> LOCKOUT, else -> ERROR.
  - Buffer and cnt are cleared on exit in both cases.
- UNLOCKED:
  - unlocked=1; timer counts UNLOCK_CYCLES.
  - Timeout or ENT -> IDLE (unlocked=0 next cycle).
  - CHG -> NEW_PW.
  - Digits and CLR are ignored.
- NEW_PW:
  - unlocked stays 1 and the timer is frozen.
  - Digits fill the buffer as in ENTRY.
  - ENT with cnt==6: stored pw <= buffer, buffer cleared -> IDLE.
  - ENT with cnt<6 is ignored.
  - CLR clears the buffer.
  - CHG aborts without committing -> IDLE.
- ERROR: err=1 for ERR_CYCLES, all keys ignored -> IDLE.
- LOCKOUT:
  - alarm=1 for LOCKOUT_CYCLES, all keys ignored.
  - On exit fail_cnt=0 -> IDLE.
- Timer: a single down-counter loaded on state entry; it is wide enough for the largest *_CYCLES value.
- Outputs:
  - a_digits always reflects the buffer.
  - b_digits always reflects the stored pw.
  - The stored pw changes only on NEW_PW commit.
- A successful unlock clears fail_cnt. Failures across separate attempts accumulate until success or lockout.

Decomposition:
- Package lock_pkg holds:
  - state enum;
  - key code constants KEY_ENT, KEY_CLR, KEY_CHG;
  - the digit-valid check (code <= 9);
  - PW_DIGITS=6.
- One natural sub-module: lock_timer, a loadable down-counter with a done pulse, shared by the UNLOCKED, ERROR and LOCKOUT states.
- judge stays external and is instantiated beside lock_ctrl at top level.

Test Plan:
- Correct code: reset, key 1,2,3,4,5,6,ENT -> judge_s one-cycle pulse, a_digits=24'h123456 -> unlocked=1 in EVAL+1. unlocked stays high UNLOCK_CYCLES (scale params down in the bench), then returns to 0 and state is IDLE.
- Lockout: three wrong entries of 1,1,1,1,1,1,ENT -> err pulses after attempts 1 and 2. After attempt 3, alarm=1 for LOCKOUT_CYCLES. Keys during lockout change nothing. fail_cnt is back to 0 afterwards.
- Short entry: 1,2,3,ENT -> err=1 and fail_cnt=1. A 7th digit after six is ignored (a_digits unchanged, digit_cnt=6). CLR mid-entry -> digit_cnt=0.
- Change password: unlock, CHG, 9,8,7,6,5,4,ENT -> b_digits=24'h987654. The old code now fails and 9,8,7,6,5,4,ENT unlocks. A CHG abort leaves b_digits unchanged.
- Reset mid-operation: assert rst_n low during EVAL, during UNLOCKED, and during LOCKOUT -> all outputs 0 immediately, b_digits=DEFAULT_PW, digit_cnt=0.
